// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: scan codes, frame states
// and the mapping from scan codes to the eight held-key bits.
package ps2_pkg;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam int NUM_KEYS = 8;
    localparam logic [2:0] KEY_P1_UP    = 3'd0;
    localparam logic [2:0] KEY_P1_DOWN  = 3'd1;
    localparam logic [2:0] KEY_P1_LEFT  = 3'd2;
    localparam logic [2:0] KEY_P1_RIGHT = 3'd3;
    localparam logic [2:0] KEY_P2_UP    = 3'd4;
    localparam logic [2:0] KEY_P2_DOWN  = 3'd5;
    localparam logic [2:0] KEY_P2_LEFT  = 3'd6;
    localparam logic [2:0] KEY_P2_RIGHT = 3'd7;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_map_t;

    // Player 1 keys are plain codes, player 2 keys only match with the E0 prefix.
    function automatic key_map_t map_key(input logic i_ext, input logic [7:0] i_sc);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = KEY_P1_UP;
        case ({i_ext, i_sc})
            {1'b0, SC_W}:     m.idx = KEY_P1_UP;
            {1'b0, SC_S}:     m.idx = KEY_P1_DOWN;
            {1'b0, SC_A}:     m.idx = KEY_P1_LEFT;
            {1'b0, SC_D}:     m.idx = KEY_P1_RIGHT;
            {1'b1, SC_UP}:    m.idx = KEY_P2_UP;
            {1'b1, SC_DOWN}:  m.idx = KEY_P2_DOWN;
            {1'b1, SC_LEFT}:  m.idx = KEY_P2_LEFT;
            {1'b1, SC_RIGHT}: m.idx = KEY_P2_RIGHT;
            default:          m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 pins and debounces the clock line, producing a
// one-cycle pulse on each filtered falling edge alongside the synchronized data.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_fall,
    output logic o_data
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic [CW-1:0] r_stable_cnt;
    logic          r_clk_filt;
    logic          r_fall;
    logic          w_diff;
    logic          w_flip;

    // The filtered level resets low so a line that idles high never yields a false edge.
    assign w_diff = (r_clk_sync[1] != r_clk_filt);
    assign w_flip = w_diff && (r_stable_cnt == CW'(FILTER_LEN - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync   <= '0;
            r_data_sync  <= '0;
            r_stable_cnt <= '0;
            r_clk_filt   <= 1'b0;
            r_fall       <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_fall      <= w_flip && r_clk_filt;
            if (!w_diff || w_flip) begin
                r_stable_cnt <= '0;
            end else begin
                r_stable_cnt <= r_stable_cnt + 1'b1;
            end
            if (w_flip) begin
                r_clk_filt <= ~r_clk_filt;
            end
        end
    end

    assign o_fall = r_fall;
    assign o_data = r_data_sync[1];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: deframes scan-code set 2 bytes, strips E0/F0 prefixes
// and tracks the held state of the eight game keys.
import ps2_pkg::*;

module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_p1_up,
    output logic       o_p1_down,
    output logic       o_p1_left,
    output logic       o_p1_right,
    output logic       o_p2_up,
    output logic       o_p2_down,
    output logic       o_p2_left,
    output logic       o_p2_right,
    output logic [7:0] o_code,
    output logic       o_code_valid,
    output logic       o_code_ext,
    output logic       o_code_break,
    output logic       o_parity_err,
    output logic       o_frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic                w_fall;
    logic                w_data;
    frame_state_t        r_state;
    frame_state_t        w_state_next;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_parity;
    logic [TO_W-1:0]     r_timeout;
    logic                w_done;
    logic                w_par_bad;
    logic                w_frm_bad;
    logic                r_evt_done;
    logic                r_evt_perr;
    logic                r_evt_ferr;
    logic [7:0]          r_evt_byte;
    logic                r_ext_pend;
    logic                r_brk_pend;
    logic [NUM_KEYS-1:0] r_keys;
    key_map_t            w_map;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ps2_clk  (i_ps2_clk),
        .i_ps2_data (i_ps2_data),
        .o_fall     (w_fall),
        .o_data     (w_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A stalled frame is abandoned once the counter reaches its limit.
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_par_bad    = 1'b0;
        w_frm_bad    = 1'b0;
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_data) begin
                        w_state_next = ST_DATA;
                    end else begin
                        w_frm_bad = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = ST_PARITY;
                    end
                end
                ST_PARITY: w_state_next = ST_STOP;
                ST_STOP: begin
                    w_state_next = ST_IDLE;
                    if (!w_data) begin
                        w_frm_bad = 1'b1;
                    end else if (^{r_shift, r_parity}) begin
                        w_done = 1'b1;
                    end else begin
                        w_par_bad = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end else if ((r_state != ST_IDLE) && (r_timeout == TO_W'(TIMEOUT_CYCLES))) begin
            w_state_next = ST_IDLE;
            w_frm_bad    = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_timeout <= '0;
        end else begin
            if (w_fall) begin
                case (r_state)
                    ST_IDLE: r_bit_cnt <= '0;
                    ST_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    ST_PARITY: r_parity <= w_data;
                    default: ;
                endcase
            end
            if ((r_state == ST_IDLE) || w_fall) begin
                r_timeout <= '0;
            end else if (r_timeout != TO_W'(TIMEOUT_CYCLES)) begin
                r_timeout <= r_timeout + 1'b1;
            end
        end
    end

    // Frame outcome is staged one cycle so decode sees a stable byte and flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_evt_done <= 1'b0;
            r_evt_perr <= 1'b0;
            r_evt_ferr <= 1'b0;
            r_evt_byte <= '0;
        end else begin
            r_evt_done <= w_done;
            r_evt_perr <= w_par_bad;
            r_evt_ferr <= w_frm_bad;
            if (w_done) begin
                r_evt_byte <= r_shift;
            end
        end
    end

    assign w_map = map_key(r_ext_pend, r_evt_byte);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
            r_keys       <= '0;
            o_code       <= '0;
            o_code_valid <= 1'b0;
            o_code_ext   <= 1'b0;
            o_code_break <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_code_valid <= 1'b0;
            o_parity_err <= r_evt_perr;
            o_frame_err  <= r_evt_ferr;
            if (r_evt_perr || r_evt_ferr) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else if (r_evt_done) begin
                if (r_evt_byte == SC_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (r_evt_byte == SC_BREAK) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    o_code       <= r_evt_byte;
                    o_code_ext   <= r_ext_pend;
                    o_code_break <= r_brk_pend;
                    o_code_valid <= 1'b1;
                    if (w_map.hit) begin
                        r_keys[w_map.idx] <= ~r_brk_pend;
                    end
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                end
            end
        end
    end

    assign o_p1_up    = r_keys[KEY_P1_UP];
    assign o_p1_down  = r_keys[KEY_P1_DOWN];
    assign o_p1_left  = r_keys[KEY_P1_LEFT];
    assign o_p1_right = r_keys[KEY_P1_RIGHT];
    assign o_p2_up    = r_keys[KEY_P2_UP];
    assign o_p2_down  = r_keys[KEY_P2_DOWN];
    assign o_p2_left  = r_keys[KEY_P2_LEFT];
    assign o_p2_right = r_keys[KEY_P2_RIGHT];

endmodule
